// File: rtl/dma_pkg.sv
// Shared types for the DMA descriptor schedulers: FSM encoding, descriptor
// record layout and the channel error-code width.
package dma_pkg;

  localparam int ERR_W     = 4;
  localparam int DMA_TAG_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    WAIT,
    CLR,
    DRAIN,
    DONE
  } dsched_st_t;

  typedef struct packed {
    logic [31:0]          sa;
    logic [31:0]          len;
    logic [DMA_TAG_W-1:0] tag;
  } dma_desc_t;

endpackage

// File: rtl/dma_desc_sched_fifo.sv
// Generic synchronous FIFO with extra-MSB pointers; shared by the read and
// write descriptor schedulers. Head entry is presented combinationally.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 68
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr, do_rd;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // A pop frees the slot being written, so a full FIFO may still take a push.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  assign wptr_d  = do_wr ? wptr_q + (AW+1)'(1) : wptr_q;
  assign rptr_d  = do_rd ? rptr_q + (AW+1)'(1) : rptr_q;
  assign rd_data = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/dma_desc_sched.sv
// Descriptor scheduler for one DMA channel: queues descriptors, issues them
// over cfg_dma, waits for the completion irq (with watchdog) and reports it.
module dma_desc_sched
  import dma_pkg::*;
#(
  parameter int DESC_D = 4,
  parameter int TAG_W  = 4,
  parameter int TO_CYC = 65536
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             desc_valid,
  output logic             desc_ready,
  input  logic [31:0]      desc_sa,
  input  logic [31:0]      desc_len,
  input  logic [TAG_W-1:0] desc_tag,
  output logic             cfg_dma_valid,
  input  logic             cfg_dma_ready,
  output logic [31:0]      cfg_dma_sa,
  output logic [31:0]      cfg_dma_len,
  input  logic             dma_irq,
  input  logic [ERR_W-1:0] dma_err,
  output logic             dma_irq_w1c,
  output logic             done_valid,
  input  logic             done_ready,
  output logic [TAG_W-1:0] done_tag,
  output logic [ERR_W-1:0] done_err,
  output logic             done_zl,
  output logic             done_to,
  output logic             busy
);

  localparam int CNT_W = $clog2(TO_CYC);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TO_CYC - 1);

  // Same layout as dma_desc_t, but following this instance's TAG_W.
  typedef struct packed {
    logic [31:0]      sa;
    logic [31:0]      len;
    logic [TAG_W-1:0] tag;
  } desc_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  dsched_st_t       st_q;
  logic             cfg_valid_q;
  logic [31:0]      cfg_sa_q, cfg_len_q;
  logic             w1c_q;
  logic             done_valid_q;
  logic [TAG_W-1:0] done_tag_q;
  logic [ERR_W-1:0] done_err_q;
  logic             done_zl_q, done_to_q;
  logic [TAG_W-1:0] cur_tag_q;
  logic [ERR_W-1:0] err_q;
  logic [CNT_W-1:0] wd_q;

  desc_t push_desc, head;
  logic  fifo_full, fifo_empty, fifo_push, fifo_pop;

  assign push_desc = '{sa: desc_sa, len: desc_len, tag: desc_tag};
  assign fifo_push = desc_valid && !fifo_full;
  assign fifo_pop  = (st_q == IDLE) && !fifo_empty;

  sync_fifo #(
    .DEPTH (DESC_D),
    .WIDTH ($bits(desc_t))
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (fifo_push),
    .wr_data (push_desc),
    .full    (fifo_full),
    .rd_en   (fifo_pop),
    .rd_data (head),
    .empty   (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q         <= IDLE;
      cfg_valid_q  <= 1'b0;
      cfg_sa_q     <= '0;
      cfg_len_q    <= '0;
      w1c_q        <= 1'b0;
      done_valid_q <= 1'b0;
      done_tag_q   <= '0;
      done_err_q   <= '0;
      done_zl_q    <= 1'b0;
      done_to_q    <= 1'b0;
      wd_q         <= '0;
    end else begin
      w1c_q <= 1'b0;
      unique case (st_q)
        IDLE: begin
          if (!fifo_empty) begin
            if (head.len != 32'd0) begin
              st_q        <= CFG;
              cfg_valid_q <= 1'b1;
              cfg_sa_q    <= head.sa;
              cfg_len_q   <= head.len;
              cur_tag_q   <= head.tag;
            end else begin
              st_q         <= DONE;
              done_valid_q <= 1'b1;
              done_tag_q   <= head.tag;
              done_err_q   <= '0;
              done_zl_q    <= 1'b1;
              done_to_q    <= 1'b0;
            end
          end
        end
        CFG: begin
          if (cfg_dma_ready) begin
            st_q        <= WAIT;
            cfg_valid_q <= 1'b0;
            wd_q        <= '0;
          end
        end
        WAIT: begin
          // A completing irq takes priority over a coincident timeout.
          if (dma_irq) begin
            st_q  <= CLR;
            err_q <= dma_err;
            w1c_q <= 1'b1;
          end else if (wd_q == WD_LAST) begin
            st_q         <= DONE;
            done_valid_q <= 1'b1;
            done_tag_q   <= cur_tag_q;
            done_err_q   <= '0;
            done_zl_q    <= 1'b0;
            done_to_q    <= 1'b1;
          end else begin
            wd_q <= sat_inc(wd_q);
          end
        end
        CLR: begin
          st_q <= DRAIN;
        end
        DRAIN: begin
          // Hold off until the level drops so it cannot complete the next descriptor.
          if (!dma_irq) begin
            st_q         <= DONE;
            done_valid_q <= 1'b1;
            done_tag_q   <= cur_tag_q;
            done_err_q   <= err_q;
            done_zl_q    <= 1'b0;
            done_to_q    <= 1'b0;
          end
        end
        DONE: begin
          if (done_ready) begin
            st_q         <= IDLE;
            done_valid_q <= 1'b0;
          end
        end
        default: st_q <= IDLE;
      endcase
    end
  end

  assign desc_ready    = !fifo_full;
  assign cfg_dma_valid = cfg_valid_q;
  assign cfg_dma_sa    = cfg_sa_q;
  assign cfg_dma_len   = cfg_len_q;
  assign dma_irq_w1c   = w1c_q;
  assign done_valid    = done_valid_q;
  assign done_tag      = done_tag_q;
  assign done_err      = done_err_q;
  assign done_zl       = done_zl_q;
  assign done_to       = done_to_q;
  assign busy          = (st_q != IDLE) || !fifo_empty;

endmodule
